// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: reset vector, NOP encoding, fetch FSM
// state and the fetch-to-decode payload.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP              = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;
  localparam logic [XLEN-1:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_pc_inc.sv
// Sequential-PC incrementer; wraps modulo 2^32.
module fetch_unit_pc_inc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4_c
);

  assign pc_plus4_c = pc + PC_STEP;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem read channel and a
// one-entry buffer toward decode, with redirect squash of in-flight fetches.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, req_pc_q, pc_plus4_c;
  logic            buf_valid_q, drop_q;
  fetch_entry_t    buf_q;
  logic            req_fire_c, rsp_take_c, deliver_c;

  fetch_unit_pc_inc u_pc_inc (
    .pc         (pc_q),
    .pc_plus4_c (pc_plus4_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= REQ;
    else        state_q <= state_d;
  end

  // Next state: a redirect in REQ suppresses the request, so no extra term here
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ:     if (req_fire_c)     state_d = WAIT;
      WAIT:    if (imem_rsp_valid) state_d = REQ;
      default:                     state_d = REQ;
    endcase
  end

  // Outputs; the request is held off while reset is asserted
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = pc_q;
    if_valid       = buf_valid_q && !redirect_valid;
    if (state_q == REQ)
      imem_req_valid = rst_n && !redirect_valid && (!buf_valid_q || if_ready);
  end

  assign req_fire_c = imem_req_valid && imem_req_ready;
  assign rsp_take_c = (state_q == WAIT) && imem_rsp_valid && !drop_q && !redirect_valid;
  assign deliver_c  = if_valid && if_ready;
  assign if_pc      = buf_q.pc;
  assign if_instr   = buf_q.instr;

  // PC and outstanding-request address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      if (redirect_valid)  pc_q <= redirect_pc & PC_ALIGN_MASK;
      else if (req_fire_c) pc_q <= pc_plus4_c;
      if (req_fire_c)      req_pc_q <= pc_q;
    end
  end

  // Output buffer; a same-cycle refill wins over the drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_q       <= '{pc: '0, instr: NOP};
    end else begin
      if (redirect_valid)  buf_valid_q <= 1'b0;
      else if (rsp_take_c) buf_valid_q <= 1'b1;
      else if (deliver_c)  buf_valid_q <= 1'b0;
      if (rsp_take_c)      buf_q <= '{pc: req_pc_q, instr: imem_rsp_data};
    end
  end

  // Drop flag: the response still owed for a squashed request must be discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else if (state_q == WAIT) begin
      if (imem_rsp_valid)      drop_q <= 1'b0;
      else if (redirect_valid) drop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a responding memory, a PC/fetch-order model
// fed at request acceptance, and a monitor that checks every delivery.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
  localparam logic [31:0] XOR_K  = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc;
  int          n_pass = 0;
  int          n_total = 0;
  int          deliv_cnt = 0;
  logic [31:0] last_pc;

  logic        s_req_valid, s_if_valid, s_acc;
  logic [31:0] s_acc_addr;

  logic        mem_pend = 1'b0;
  logic        mem_stale = 1'b0;
  logic [31:0] mem_addr;
  int          mem_cnt;
  logic        rand_lat = 1'b0;
  int          lat_fixed = 0;

  logic        hold_q = 1'b0;
  logic [31:0] hold_pc, hold_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One cycle: sample at negedge (model + acceptance), then drive memory after posedge
  task automatic step();
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_if_valid  = if_valid;
    s_acc       = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      model_pc = RST_PC;
      if (mem_pend) mem_stale = 1'b1;
    end else begin
      if (mem_pend && !mem_stale) chk("no_req_while_pending", 32'(imem_req_valid), 32'd0);
      if (redirect_valid) begin
        chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        exp_q.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", imem_req_addr, model_pc);
        exp_q.push_back('{pc: model_pc, instr: model_pc ^ XOR_K});
        model_pc   = model_pc + 32'd4;
        s_acc      = 1'b1;
        s_acc_addr = imem_req_addr;
      end
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    if (s_acc) begin
      mem_pend  = 1'b1;
      mem_stale = 1'b0;
      mem_addr  = s_acc_addr;
      mem_cnt   = rand_lat ? int'($urandom_range(0, 2)) : lat_fixed;
    end
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_addr ^ XOR_K;
        mem_pend       = 1'b0;
        mem_stale      = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  // Monitor: reset values, redirect masking, stall stability, delivered entries
  always @(negedge clk) begin
    if (rst_n === 1'b0) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_if_valid", 32'(if_valid), 32'd0);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_instr", if_instr, 32'h0000_0000);
      hold_q = 1'b0;
    end else if (rst_n === 1'b1) begin
      if (redirect_valid) chk("if_valid_on_redirect", 32'(if_valid), 32'd0);
      if (hold_q && if_valid) begin
        chk("hold_pc", if_pc, hold_pc);
        chk("hold_instr", if_instr, hold_instr);
      end
      if (if_valid && !if_ready) begin
        chk("no_req_when_full", 32'(imem_req_valid), 32'd0);
        hold_q     = 1'b1;
        hold_pc    = if_pc;
        hold_instr = if_instr;
      end else begin
        hold_q = 1'b0;
      end
      if (if_valid && if_ready) begin
        exp_t e;
        deliv_cnt++;
        last_pc = if_pc;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_deliver: got pc %h, expected no delivery", if_pc);
        end else begin
          e = exp_q.pop_front();
          chk("deliver_pc", if_pc, e.pc);
          chk("deliver_instr", if_instr, e.instr);
        end
      end
    end
  end

  initial begin
    logic ok;
    int   d0;
    rst_n          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    model_pc       = RST_PC;
    #1 rst_n = 1'b0;
    repeat (3) step();

    // Release: first request at the reset vector in the very next cycle
    imem_req_ready = 1'b1;
    if_ready       = 1'b1;
    rst_n          = 1'b1;
    step();
    chk("first_req_valid", 32'(s_req_valid), 32'd1);
    chk("first_req_addr", s_acc_addr, RST_PC);
    repeat (6) step();
    d0 = deliv_cnt;
    repeat (20) step();
    chk("throughput_1cyc_mem", 32'(deliv_cnt - d0), 32'd10);

    // Decode stall with a full buffer, then release
    if_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = s_if_valid; end
    chk("wait_buf_full", 32'(ok), 32'd1);
    repeat (5) begin
      step();
      chk("stall_no_req", 32'(s_req_valid), 32'd0);
      chk("stall_if_valid", 32'(s_if_valid), 32'd1);
    end
    if_ready = 1'b1;
    step();
    chk("req_on_release", 32'(s_req_valid), 32'd1);

    // Redirect while a request is outstanding
    lat_fixed = 2;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = s_acc; end
    chk("wait_accept_a", 32'(ok), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1002;
    step();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = s_acc; end
    chk("redir_wait_target", s_acc_addr, 32'h0000_1000);

    // Redirect coincident with the response
    lat_fixed = 0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = imem_rsp_valid; end
    chk("wait_rsp", 32'(ok), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2ABD;
    step();
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = s_acc; end
    chk("redir_rsp_target", s_acc_addr, 32'h0000_2ABC);

    // Redirect with the buffer full; target wraps past the top of memory
    if_ready = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = s_if_valid; end
    chk("wait_buf_full_b", 32'(ok), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    step();
    chk("buf_cleared_after_redirect", 32'(s_if_valid), 32'd0);
    chk("wrap_first_req", s_acc_addr, 32'hFFFF_FFFC);
    if_ready = 1'b1;
    repeat (8) step();

    // Reset during WAIT; stale response lands one cycle after release
    lat_fixed = 2;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin step(); ok = s_acc; end
    chk("wait_accept_r", 32'(ok), 32'd1);
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    imem_req_ready = 1'b1;
    d0 = deliv_cnt;
    for (int i = 0; i < 20 && deliv_cnt == d0; i++) step();
    chk("post_reset_first_pc", last_pc, RST_PC);

    // Randomized traffic
    rand_lat = 1'b1;
    repeat (3000) begin
      step();
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom();
      end
    end
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end of the MIPS datapath. Holds the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and delivers the fetched instruction with its PC to decode through a one-entry output buffer. Branch/jump redirects from execute overwrite the PC and squash any in-flight or buffered fetch.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  taken branch/jump from execute
- redirect_pc  in  32  redirect target; bits [1:0] treated as 0
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  32  read address (current PC)
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  read data valid (one pulse per accepted request)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  buffered instruction available to decode
- if_pc  out  32  PC of buffered instruction
- if_instr  out  32  buffered instruction
- if_ready  in  1  decode accepts instruction

## Operation
- States: REQ (may issue), WAIT (one request outstanding). Plus buf_valid and drop flag registers.
- REQ: imem_req_valid = !redirect_valid && (!buf_valid || if_ready); imem_req_addr = pc. On valid && ready: go WAIT, record req_pc = pc, pc <= pc + 4.
- WAIT: no request. On imem_rsp_valid: if drop, discard and clear drop; else buf <= {req_pc, imem_rsp_data}, buf_valid <= 1. Go REQ.
- Issue rule guarantees the buffer is empty (or draining this cycle) when the response lands; no overflow possible.
- Output: if_valid = buf_valid && !redirect_valid. Transfer on if_valid && if_ready clears buf_valid unless refilled same cycle (refill wins).
- Redirect (highest priority): pc <= {redirect_pc[31:2],2'b00}; buf_valid <= 0; in WAIT set drop (unless response arrives same cycle, which is discarded directly and state goes REQ with drop clear); in REQ no request issues that cycle.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- imem_rsp_valid in REQ is ignored.

## Timing
- Reset (async assert): state REQ, pc = RESET_PC, buf_valid 0, drop 0, if_pc 0, if_instr 32'h0 (NOP), imem_req_valid 0 while rst_n low.
- First request in the first cycle after rst_n deasserts, addr RESET_PC.
- Latency: request accept edge -> WAIT; response edge -> if_valid high the next cycle. 1-cycle memory gives one instruction per 2 cycles.
- Redirect takes effect at the next edge; new-target request issues in the first REQ cycle after.
- Reset mid-WAIT: outstanding response after reset ignored (arrives in REQ).

## Structure
- Shared package mips_pkg: RESET_PC default, NOP encoding 32'h0000_0000, fetch state enum {REQ, WAIT}.
- Sub-module: reuse the team's existing PC+4 incrementer for pc + 4; all else in one module.

## Test plan
- Reset, memory ready always, 1-cycle latency, data = addr ^ 32'hA5A5_A5A5 -> if_pc sequence 0x0, 0x4, 0x8, one per 2 cycles, if_instr matches.
- if_ready held low 5 cycles with buffer full -> imem_req_valid stays 0, if_pc/if_instr stable; release -> request for next PC same cycle.
- Redirect to 32'h0000_1002 while WAIT -> that response dropped, next request addr 32'h0000_1000, no if_valid for the old PC.
- Redirect in same cycle as imem_rsp_valid and with buf_valid high -> if_valid low that cycle, buffer cleared, next request at target.
- RESET_PC = 32'hFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst_n pulsed low during WAIT, stale rsp arrives 1 cycle after release -> ignored, first delivered instruction has if_pc = RESET_PC.
